// File: rtl/uart_buf_pkg.sv
// Shared types and default character codes for the UART receive line buffer.
package uart_buf_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_BS = 8'h08;
    localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/line_ram.sv
// Single-write, synchronous-read line storage. Reads return the pre-write
// contents on a same-address collision; out-of-range reads return zero.
module line_ram #(
    parameter int DEPTH  = 100,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_rd_ok;

    assign w_rd_ok = ({1'b0, i_raddr} < DEPTH_C);
    assign o_rdata = r_rdata;

    // Storage itself is never reset; only the output register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (w_rd_ok) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= '0;
        end
    end

endmodule

// File: rtl/uart_rx_line_buffer.sv
// Collects UART bytes into a line until the terminator arrives, then holds the
// line for random-access readout until Clear. Supports backspace editing.
module uart_rx_line_buffer
    import uart_buf_pkg::*;
#(
    parameter int                DEPTH   = 100,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] TERM    = CHAR_CR,
    parameter bit                BS_EN   = 1'b1,
    parameter logic [DATA_W-1:0] BS_CHAR = CHAR_BS,
    parameter int                ADDR_W  = $clog2(DEPTH)
) (
    input  logic              Clk_100M,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Rx_Data,
    input  logic              Rx_Ready,
    output logic              Rx_Ack,
    input  logic              Clear,
    input  logic [ADDR_W-1:0] Rd_Addr,
    output logic [DATA_W-1:0] Rd_Data,
    output logic              Line_Valid,
    output logic [ADDR_W:0]   Line_Len,
    output logic              Overflow
);

    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prev_rdy;
    logic             r_ack;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             w_evt;
    logic             w_we;

    // Rising edge of the receiver idle level marks a freshly received byte.
    assign w_evt = ~r_prev_rdy & Rx_Ready;

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_state    <= FILL;
            r_prev_rdy <= 1'b1;
            r_ack      <= 1'b0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev_rdy <= Rx_Ready;
            r_ack      <= w_evt;
            r_len      <= w_len_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_ovf_nxt   = r_ovf;
        w_we        = 1'b0;
        if (Reset) begin
            w_we = 1'b0;
        end else if (Clear) begin
            // Clear beats a coincident byte; the byte is still acked.
            w_state_nxt = FILL;
            w_len_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else if (w_evt) begin
            case (r_state)
                FILL: begin
                    if (Rx_Data == TERM) begin
                        w_state_nxt = HOLD;
                    end else if (BS_EN && (Rx_Data == BS_CHAR)) begin
                        if (r_len != '0) begin
                            w_len_nxt = r_len - CNT_W'(1);
                        end
                    end else if (r_len < DEPTH_C) begin
                        w_we      = 1'b1;
                        w_len_nxt = r_len + CNT_W'(1);
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end
                HOLD: begin
                    w_ovf_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = FILL;
                end
            endcase
        end
    end

    line_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (Clk_100M),
        .i_rst   (Reset),
        .i_we    (w_we),
        .i_waddr (r_len[ADDR_W-1:0]),
        .i_wdata (Rx_Data),
        .i_raddr (Rd_Addr),
        .o_rdata (Rd_Data)
    );

    assign Rx_Ack     = r_ack;
    assign Line_Valid = (r_state == HOLD);
    assign Line_Len   = r_len;
    assign Overflow   = r_ovf;

endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// Directed bench: instance A uses default DEPTH=100, instance B uses DEPTH=4.
module tb_uart_rx_line_buffer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rxa, rxb;
    logic       rdya, rdyb, clra, clrb, acka, ackb;
    logic [6:0] addra;
    logic [1:0] addrb;
    logic [7:0] rda, rdb;
    logic       vala, valb, ovfa, ovfb;
    logic [7:0] lena;
    logic [2:0] lenb;

    int n_chk = 0;
    int n_err = 0;
    int ack_cnt_a = 0;
    int base;

    uart_rx_line_buffer dut_a (
        .Clk_100M (clk), .Reset (rst), .Rx_Data (rxa), .Rx_Ready (rdya),
        .Rx_Ack (acka), .Clear (clra), .Rd_Addr (addra), .Rd_Data (rda),
        .Line_Valid (vala), .Line_Len (lena), .Overflow (ovfa)
    );

    uart_rx_line_buffer #(.DEPTH(4)) dut_b (
        .Clk_100M (clk), .Reset (rst), .Rx_Data (rxb), .Rx_Ready (rdyb),
        .Rx_Ack (ackb), .Clear (clrb), .Rd_Addr (addrb), .Rd_Data (rdb),
        .Line_Valid (valb), .Line_Len (lenb), .Overflow (ovfb)
    );

    always @(negedge clk) if (acka === 1'b1) ack_cnt_a++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver model: idle level drops while a byte is in flight, rises when ready.
    task automatic send(input bit w, input logic [7:0] b, input int gap, input bit clr);
        @(negedge clk);
        if (!w) begin rdya = 1'b0; rxa = b; end
        else    begin rdyb = 1'b0; rxb = b; end
        repeat (gap) @(negedge clk);
        if (!w) begin rdya = 1'b1; clra = clr; end
        else    begin rdyb = 1'b1; clrb = clr; end
        @(negedge clk);
        check("ack_hi", w ? ackb : acka, 1);
        clra = 1'b0;
        clrb = 1'b0;
        @(negedge clk);
        check("ack_lo", w ? ackb : acka, 0);
    endtask

    task automatic rd(input bit w, input int a, input logic [7:0] exp);
        @(negedge clk);
        if (!w) addra = 7'(a); else addrb = 2'(a);
        @(negedge clk);
        check("rd_data", w ? rdb : rda, exp);
    endtask

    task automatic pulse_clear(input bit w);
        @(negedge clk);
        if (!w) clra = 1'b1; else clrb = 1'b1;
        @(negedge clk);
        clra = 1'b0;
        clrb = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdya = 1'b1; rdyb = 1'b1; clra = 1'b0; clrb = 1'b0;
        rxa = 8'h00; rxb = 8'h00; addra = '0; addrb = '0;
        repeat (3) @(negedge clk);
        check("rst_len",   lena, 0);
        check("rst_valid", vala, 0);
        check("rst_ovf",   ovfa, 0);
        check("rst_ack",   acka, 0);
        check("rst_rd",    rda,  0);
        check("rst_len_b", lenb, 0);
        rst = 1'b0;

        // Basic line "ABC" + CR, 200 cycles apart
        base = ack_cnt_a;
        send(0, 8'h41, 199, 0);
        send(0, 8'h42, 199, 0);
        send(0, 8'h43, 199, 0);
        send(0, 8'h0D, 199, 0);
        check("abc_valid", vala, 1);
        check("abc_len",   lena, 3);
        check("abc_ovf",   ovfa, 0);
        check("abc_acks",  ack_cnt_a - base, 4);
        rd(0, 0, 8'h41);
        rd(0, 1, 8'h42);
        rd(0, 2, 8'h43);
        rd(0, 120, 8'h00);

        // Backspace editing
        pulse_clear(0);
        check("clr_valid", vala, 0);
        check("clr_len",   lena, 0);
        send(0, 8'h58, 4, 0);
        send(0, 8'h59, 4, 0);
        send(0, 8'h08, 4, 0);
        send(0, 8'h5A, 4, 0);
        send(0, 8'h0D, 4, 0);
        check("bs_len",   lena, 2);
        check("bs_valid", vala, 1);
        rd(0, 0, 8'h58);
        rd(0, 1, 8'h5A);
        pulse_clear(0);
        send(0, 8'h08, 4, 0);
        check("bs0_len",   lena, 0);
        check("bs0_valid", vala, 0);
        send(0, 8'h0D, 4, 0);
        check("empty_valid", vala, 1);
        check("empty_len",   lena, 0);
        pulse_clear(0);

        // Bytes arriving in HOLD are dropped and flag overflow
        send(0, 8'h51, 4, 0);
        send(0, 8'h52, 4, 0);
        send(0, 8'h0D, 4, 0);
        check("hold_len0", lena, 2);
        check("hold_ovf0", ovfa, 0);
        send(0, 8'h55, 4, 0);
        check("hold_ovf",   ovfa, 1);
        check("hold_len",   lena, 2);
        check("hold_valid", vala, 1);
        rd(0, 2, 8'h43);
        rd(0, 0, 8'h51);
        pulse_clear(0);
        check("hclr_valid", vala, 0);
        check("hclr_len",   lena, 0);
        check("hclr_ovf",   ovfa, 0);
        send(0, 8'h61, 4, 0);
        check("after_len", lena, 1);
        rd(0, 0, 8'h61);

        // Same-cycle write and read of address 1 returns the old byte
        @(negedge clk);
        addra = 7'd1; rdya = 1'b0; rxa = 8'h62;
        repeat (3) @(negedge clk);
        rdya = 1'b1;
        @(negedge clk);
        check("rf_old", rda, 8'h52);
        @(negedge clk);
        check("rf_new", rda, 8'h62);
        check("rf_len", lena, 2);

        // Clear coincident with a byte event
        pulse_clear(0);
        send(0, 8'h31, 4, 0);
        send(0, 8'h32, 4, 0);
        send(0, 8'h41, 4, 1);
        check("cc_len",   lena, 0);
        check("cc_ovf",   ovfa, 0);
        check("cc_valid", vala, 0);
        rd(0, 0, 8'h31);
        rd(0, 2, 8'h43);

        // DEPTH=4 overflow
        for (int i = 1; i <= 4; i++) send(1, 8'(i), 4, 0);
        check("full_len", lenb, 4);
        check("full_ovf", ovfb, 0);
        send(1, 8'h05, 4, 0);
        check("of_ovf",   ovfb, 1);
        check("of_valid", valb, 0);
        check("of_len",   lenb, 4);
        send(1, 8'h06, 4, 0);
        send(1, 8'h0D, 4, 0);
        check("of_term_valid", valb, 1);
        check("of_term_len",   lenb, 4);
        check("of_term_ovf",   ovfb, 1);
        for (int i = 0; i < 4; i++) rd(1, i, 8'(i + 1));
        send(1, 8'h77, 4, 1);
        check("bcc_ovf",   ovfb, 0);
        check("bcc_len",   lenb, 0);
        check("bcc_valid", valb, 0);

        // Reset mid-line with the receiver idle
        pulse_clear(0);
        send(0, 8'h71, 4, 0);
        send(0, 8'h72, 4, 0);
        send(0, 8'h73, 4, 0);
        check("pre_rst_len", lena, 3);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mr_len",   lena, 0);
        check("mr_valid", vala, 0);
        check("mr_ovf",   ovfa, 0);
        check("mr_ack",   acka, 0);
        check("mr_rd",    rda,  0);
        base = ack_cnt_a;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mr_no_evt_len", lena, 0);
        check("mr_no_evt_ack", ack_cnt_a - base, 0);
        send(0, 8'h74, 4, 0);
        check("mr_next_len", lena, 1);
        rd(0, 0, 8'h74);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_line_buffer.md
Name: uart_rx_line_buffer

Overview:
- Parametrised successor to the top-level fixed 100-byte receive store.
- Sits between the UART receiver and consumer logic (LED display, command decoder).
- Captures received bytes in ascending address order until a terminator character arrives, then holds the completed line for random-access readout.
- Adds terminator detection, optional backspace editing, overflow flagging, an explicit clear handshake, and a per-byte ack back to the receiver.

Parameters:
- DEPTH, 100, line storage entries (2..1024).
- DATA_W, 8, byte width.
- TERM, 8'h0D, terminator character; never stored.
- BS_EN, 1, 1 = BS_CHAR removes the last stored byte.
- BS_CHAR, 8'h08, backspace character.
- ADDR_W, clog2(DEPTH), derived; read address width. Count width is ADDR_W+1.

Ports:
- Clk_100M  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Rx_Data  in  DATA_W  byte from the UART receiver; valid when Rx_Ready rises.
- Rx_Ready  in  1  receiver idle level; a 0->1 transition marks a new byte.
- Rx_Ack  out  1  one-cycle pulse per consumed byte.
- Clear  in  1  pulse; releases a held line and empties the buffer.
- Rd_Addr  in  ADDR_W  read address.
- Rd_Data  out  DATA_W  registered read data.
- Line_Valid  out  1  a terminated line is held.
- Line_Len  out  ADDR_W+1  bytes stored (0..DEPTH).
- Overflow  out  1  sticky; at least one byte was dropped.

Behaviour:
- Reset applies on the Clk_100M edge while Reset=1:
  - State goes to FILL.
  - Line_Len=0, Line_Valid=0, Overflow=0, Rx_Ack=0, Rd_Data=0.
  - The internal previous-Rx_Ready register is set to 1, so a receiver that is already idle does not produce a false edge.
  - Memory contents are not cleared.
- Byte event: internal prev register holds Rx_Ready from the previous cycle; event = prev==0 and Rx_Ready==1. The byte is sampled that same cycle.
- Rx_Ack asserts the cycle after every byte event (accepted or dropped), for exactly one cycle.
- States: FILL, HOLD.
- FILL, on a byte event:
  - Rx_Data==TERM -> HOLD, Line_Valid=1. TERM is not stored; Line_Len unchanged.
  - BS_EN and Rx_Data==BS_CHAR -> Line_Len decrements if >0; at 0 nothing changes. Never stored.
  - Otherwise, if Line_Len<DEPTH -> mem[Line_Len]=Rx_Data, Line_Len+1.
  - Otherwise (full) -> byte dropped, Overflow=1, stay in FILL.
- HOLD, on a byte event: byte dropped, Overflow=1. Memory and Line_Len are frozen.
- Clear (either state) -> FILL, Line_Len=0, Line_Valid=0, Overflow=0 on the next edge.
- Clear and a byte event in the same cycle: Clear wins, the byte is discarded, Overflow ends at 0, and Rx_Ack still pulses.
- Empty line: TERM with Line_Len=0 -> HOLD with Line_Len=0. This is legal.
- Read path:
  - Rd_Data = mem[Rd_Addr], registered, 1-cycle latency, available in both states.
  - Rd_Addr>=DEPTH returns 0.
  - Reading an address >=Line_Len returns stale memory contents; consumers must bound reads by Line_Len.
- Write-then-read of the same address in one cycle returns the old data (read-first).
- Reset asserted mid-line: discard everything per the reset values; the next byte event writes address 0.
- No wrap-around: the buffer never overwrites from address 0 while in FILL.

Decomposition:
- Package uart_buf_pkg holds:
  - state enum {FILL, HOLD};
  - default constants CHAR_CR=8'h0D, CHAR_BS=8'h08, CHAR_LF=8'h0A.
- Sub-module line_ram(DEPTH, DATA_W): single-write, sync-read, read-first memory.
- Edge detect, the FSM and the counters stay in the top module.

Test Plan:
- Reset, then bytes "A","B","C",8'h0D spaced 200 cycles apart -> Line_Valid=1, Line_Len=3; reading addresses 0..2 returns 8'h41/8'h42/8'h43 one cycle after the address; 4 Rx_Ack pulses.
- Bytes "X","Y",8'h08,"Z",8'h0D with BS_EN=1 -> Line_Len=2, mem = "X","Z". Leading 8'h08 at Line_Len=0 -> Line_Len stays 0.
- DEPTH=4, send 6 bytes 8'h01..8'h06 then 8'h0D -> Line_Len=4, mem = 01..04, Overflow=1, Line_Valid=1.
- In HOLD, send 8'h55 -> Overflow=1, Line_Len and mem unchanged. Pulse Clear -> Line_Valid=0, Line_Len=0, Overflow=0; the next byte lands at address 0.
- Clear coincident with a byte event of 8'h41 in FILL with Line_Len=2 -> Line_Len=0, mem[0] not written, Rx_Ack pulse seen.
- Reset asserted after 3 bytes while Rx_Ready is held at 1 -> all outputs return to reset values, no spurious byte event; the next byte goes to address 0.
